mipi_rx_sync_gen: RTL and testbench
===================================

Name: mipi_rx_sync_gen

Overview:
Parametrised MIPI Rx sync generator that replaces the single-cycle HSS strobe.
- Decodes DSI/CSI short-packet sync commands (VSS 0x01, HSS 0x21) from the Rx command interface.
- Produces Hsync/Vsync pulses with programmable width, delay and polarity, plus a frame-start strobe and a line counter.
- Sits between the MIPI Rx packet decoder and the parallel-video (pinf) timing path.

Parameters:
HS_WIDTH, 1, Hsync active width in CLKn cycles; legal 1..255.
VS_WIDTH, 1, Vsync active width in CLKn cycles; legal 1..255.
DLY, 0, extra pipeline delay in cycles from decode to pulse start; legal 0..15.
HS_POL, 1, 1 = Hsync active-high, 0 = active-low.
VS_POL, 1, 1 = Vsync active-high, 0 = active-low.
LINE_CNT_W, 12, width of Line_cnt.

Ports:
CLKn  in  1  pixel/byte clock
RSTn  in  1  reset
Rx_cmd_data_type  in  6  short-packet data type
Rx_cmd_valid  in  1  qualifies Rx_cmd_data_type for one cycle
Hsync  out  1  horizontal sync, polarity HS_POL
Vsync  out  1  vertical sync, polarity VS_POL
Frame_start  out  1  one-cycle pulse at Vsync assertion, always active-high
Line_cnt  out  LINE_CNT_W  HSS count since last VSS
Line_period  out  16  cycles between last two HSS (see Optional Feature)
Sync_err  out  1  one-cycle pulse: HSS received outside a frame (see Optional Feature)

Behaviour:
- Reset: RSTn, asynchronous, active-low; clock CLKn. All state clears.
  - Hsync = ~HS_POL, Vsync = ~VS_POL.
  - Frame_start = 0, Line_cnt = 0, Line_period = 0, Sync_err = 0.
  - FSM = IDLE.
- Decode stage (registered):
  - hss_s = Rx_cmd_valid & (type == 0x21).
  - vss_s = Rx_cmd_valid & (type == 0x01).
  - All other types are ignored.
- Delay line: DLY register stages carry {vss, hss}. With DLY=0 the decoded strobes feed the pulse generators directly.
- Latency: valid sampled at edge N -> Hsync/Vsync active from edge N+1+DLY. With DLY=0, HS_WIDTH=1, HS_POL=1, Hsync matches the legacy one-cycle strobe.
- Pulse generators: independent 8-bit down-counters.
  - A strobe loads the counter with WIDTH; output is active while counter != 0.
  - Retrigger: a strobe while the pulse is active reloads WIDTH. The pulse extends with no gap.
- FSM (frame state), two states:
  - IDLE --vss--> IN_FRAME.
  - IN_FRAME --vss--> IN_FRAME (restart).
  - There is no exit other than reset.
- Frame_start pulses for one cycle on each delayed vss strobe, coincident with the first active Vsync cycle.
- Line_cnt:
  - Cleared to 0 on delayed vss.
  - +1 on delayed hss when in IN_FRAME; saturates at all-ones.
  - hss in IDLE does not count, but still produces Hsync.
  - Updates on the same edge that Hsync asserts.
- Back-to-back commands on consecutive cycles are all honoured; no event is dropped at any DLY.
- Reset mid-pulse: outputs return to inactive immediately (asynchronous) and the pipeline is flushed.

Optional Feature:
MIPI_RX_SYNC_MEAS_EN.
- Defined:
  - 16-bit cycle counter runs from each delayed hss. It clears to 1 on hss, increments per cycle and saturates at 0xFFFF.
  - On each delayed hss after the first since reset, Line_period <= counter value, i.e. the cycle distance between HSS events, saturated.
  - Sync_err pulses for one cycle on delayed hss while FSM = IDLE.
- Not defined:
  - Line_period tied to 0 and Sync_err tied to 0.
  - No measurement logic is synthesised.

Test Plan:
- Defaults, HSS at cycle 10 -> Hsync=1 at cycle 11 only; Line_cnt stays 0 (IDLE); Sync_err=1 at cycle 11 (MEAS_EN).
- VS_WIDTH=3, DLY=2; VSS at cycle 5, then HSS at cycles 20/120/220 -> Vsync high cycles 8-10; Frame_start at cycle 8; Line_cnt = 1/2/3 at cycles 23/123/223.
- HS_WIDTH=4, HSS at cycles 0 and 2 -> Hsync continuous cycles 1-6 (retrigger).
- HS_POL=0, VS_POL=0 -> both idle high after reset, pulses low; Frame_start stays active-high.
- MEAS_EN, HSS every 2200 cycles -> Line_period = 2200 after second HSS; HSS gap 70000 -> Line_period = 0xFFFF.
- RSTn low mid-Vsync with DLY=15 and events in flight -> outputs inactive immediately; no pulses after release; FSM back to IDLE.

Source files
------------

// File: rtl/mipi_rx_sync_gen_if.sv
// mipi_rx_sync_gen_if
//   Rx short-packet command bus between the MIPI Rx packet decoder and
//   the sync generator.
//   Rx_cmd_data_type : 6-bit short-packet data type
//   Rx_cmd_valid     : qualifies Rx_cmd_data_type for one cycle
//   Modports: master = packet decoder (drives), slave = sync generator.
interface mipi_rx_sync_gen_if;
    logic [5:0] Rx_cmd_data_type;
    logic       Rx_cmd_valid;

    modport master (output Rx_cmd_data_type, output Rx_cmd_valid);
    modport slave  (input  Rx_cmd_data_type, input  Rx_cmd_valid);
endinterface

// File: rtl/mipi_rx_sync_gen.sv
// mipi_rx_sync_gen
//   Decodes DSI/CSI short-packet sync commands (VSS 0x01, HSS 0x21) and
//   generates Hsync/Vsync pulses of programmable width, delay and polarity,
//   a frame-start strobe and a line counter for the pinf timing path.
//   Ports:
//     CLKn        : pixel/byte clock
//     RSTn        : asynchronous active-low reset
//     rx_cmd      : Rx command bus (mipi_rx_sync_gen_if.slave)
//     Hsync       : horizontal sync, polarity HS_POL
//     Vsync       : vertical sync, polarity VS_POL
//     Frame_start : one-cycle active-high strobe at Vsync assertion
//     Line_cnt    : HSS count since last VSS (saturating)
//     Line_period : cycles between the last two HSS (measurement build)
//     Sync_err    : one-cycle strobe on HSS outside a frame (measurement build)
//   Optional feature macro: MIPI_RX_SYNC_MEAS_EN enables Line_period and
//   Sync_err; without it both outputs are tied to 0.
module mipi_rx_sync_gen #(
    parameter int unsigned HS_WIDTH   = 1,
    parameter int unsigned VS_WIDTH   = 1,
    parameter int unsigned DLY        = 0,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned LINE_CNT_W = 12
) (
    input  logic                  CLKn,
    input  logic                  RSTn,
    mipi_rx_sync_gen_if.slave     rx_cmd,
    output logic                  Hsync,
    output logic                  Vsync,
    output logic                  Frame_start,
    output logic [LINE_CNT_W-1:0] Line_cnt,
    output logic [15:0]           Line_period,
    output logic                  Sync_err
);
    localparam logic [5:0] DT_VSS = 6'h01;
    localparam logic [5:0] DT_HSS = 6'h21;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       in_frame;
    logic [1:0] dec;      // {vss, hss} decode register
    logic [1:0] dly;      // {vss, hss} after the delay line
    logic       vss_d;
    logic       hss_d;
    logic [7:0] hs_cnt;
    logic [7:0] vs_cnt;

    // Decode stage
    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) begin
            dec <= '0;
        end else begin
            dec[0] <= rx_cmd.Rx_cmd_valid && (rx_cmd.Rx_cmd_data_type == DT_HSS);
            dec[1] <= rx_cmd.Rx_cmd_valid && (rx_cmd.Rx_cmd_data_type == DT_VSS);
        end
    end

    // Delay line: every cycle shifts, so back-to-back events are never merged
    generate
        if (DLY == 0) begin : g_nodly
            assign dly = dec;
        end else begin : g_dly
            logic [1:0] sr [DLY];
            always_ff @(posedge CLKn or negedge RSTn) begin
                if (!RSTn) begin
                    for (int unsigned i = 0; i < DLY; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= dec;
                    for (int unsigned i = 1; i < DLY; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly = sr[DLY-1];
        end
    endgenerate

    assign hss_d = dly[0];
    assign vss_d = dly[1];

    // Pulse generators: a strobe (re)loads the width, so retriggers extend
    // the pulse without a gap
    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) begin
            hs_cnt <= '0;
            vs_cnt <= '0;
        end else begin
            if (hss_d)             hs_cnt <= 8'(HS_WIDTH);
            else if (hs_cnt != '0) hs_cnt <= hs_cnt - 8'd1;
            if (vss_d)             vs_cnt <= 8'(VS_WIDTH);
            else if (vs_cnt != '0) vs_cnt <= vs_cnt - 8'd1;
        end
    end

    assign Hsync = (hs_cnt != '0) ? HS_POL : ~HS_POL;
    assign Vsync = (vs_cnt != '0) ? VS_POL : ~VS_POL;

    // Frame FSM: state register
    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Frame FSM: next state (only reset leaves IN_FRAME)
    always_comb begin
        state_nxt = state;
        if (vss_d) state_nxt = IN_FRAME;
    end

    // Frame FSM: outputs
    always_comb begin
        in_frame = 1'b0;
        case (state)
            IN_FRAME: in_frame = 1'b1;
            default:  in_frame = 1'b0;
        endcase
    end

    // Frame start and line counter
    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) begin
            Frame_start <= 1'b0;
            Line_cnt    <= '0;
        end else begin
            Frame_start <= vss_d;
            if (vss_d)
                Line_cnt <= '0;
            else if (hss_d && in_frame && (Line_cnt != '1))
                Line_cnt <= Line_cnt + LINE_CNT_W'(1);
        end
    end

`ifdef MIPI_RX_SYNC_MEAS_EN
    logic [15:0] per_cnt;
    logic        hss_seen;

    // per_cnt restarts at 1 on each HSS, so at the next HSS it holds the
    // exact cycle distance (saturated)
    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) begin
            per_cnt     <= '0;
            hss_seen    <= 1'b0;
            Line_period <= '0;
            Sync_err    <= 1'b0;
        end else begin
            Sync_err <= hss_d && !in_frame;
            if (hss_d) begin
                per_cnt  <= 16'd1;
                hss_seen <= 1'b1;
                if (hss_seen) Line_period <= per_cnt;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + 16'd1;
            end
        end
    end
`else
    assign Line_period = '0;
    assign Sync_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_rx_sync_gen.sv
// tb_mipi_rx_sync_gen
//   Drives one Rx command bus into three differently configured instances
//   of mipi_rx_sync_gen and compares every output each cycle against an
//   event-time model, plus directed literal expectations.
module tb_mipi_rx_sync_gen;
    localparam int NI = 3;
    localparam int P_HW [NI] = '{1, 4, 2};
    localparam int P_VW [NI] = '{1, 3, 5};
    localparam int P_DL [NI] = '{0, 2, 15};
    localparam bit P_HP [NI] = '{1'b1, 1'b1, 1'b0};
    localparam bit P_VP [NI] = '{1'b1, 1'b1, 1'b0};
    localparam int P_LW [NI] = '{12, 2, 12};
`ifdef MIPI_RX_SYNC_MEAS_EN
    localparam bit MEAS_ON = 1'b1;
`else
    localparam bit MEAS_ON = 1'b0;
`endif
    localparam logic [5:0] HSS = 6'h21;
    localparam logic [5:0] VSS = 6'h01;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mipi_rx_sync_gen_if bus();

    logic        hs [NI];
    logic        vs [NI];
    logic        fs [NI];
    logic        se [NI];
    logic [15:0] lp [NI];
    logic [11:0] lc0;
    logic [1:0]  lc1;
    logic [11:0] lc2;

    mipi_rx_sync_gen u0 (
        .CLKn(clk), .RSTn(rstn), .rx_cmd(bus),
        .Hsync(hs[0]), .Vsync(vs[0]), .Frame_start(fs[0]),
        .Line_cnt(lc0), .Line_period(lp[0]), .Sync_err(se[0])
    );

    mipi_rx_sync_gen #(
        .HS_WIDTH(4), .VS_WIDTH(3), .DLY(2), .HS_POL(1'b1), .VS_POL(1'b1), .LINE_CNT_W(2)
    ) u1 (
        .CLKn(clk), .RSTn(rstn), .rx_cmd(bus),
        .Hsync(hs[1]), .Vsync(vs[1]), .Frame_start(fs[1]),
        .Line_cnt(lc1), .Line_period(lp[1]), .Sync_err(se[1])
    );

    mipi_rx_sync_gen #(
        .HS_WIDTH(2), .VS_WIDTH(5), .DLY(15), .HS_POL(1'b0), .VS_POL(1'b0), .LINE_CNT_W(12)
    ) u2 (
        .CLKn(clk), .RSTn(rstn), .rx_cmd(bus),
        .Hsync(hs[2]), .Vsync(vs[2]), .Frame_start(fs[2]),
        .Line_cnt(lc2), .Line_period(lp[2]), .Sync_err(se[2])
    );

    // Event log: edge number at which each accepted command was sampled
    int edge_n = 0;
    int hq[$];
    int vq[$];

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rstn && bus.Rx_cmd_valid) begin
            if (bus.Rx_cmd_data_type == HSS)      hq.push_back(edge_n);
            else if (bus.Rx_cmd_data_type == VSS) vq.push_back(edge_n);
        end
    end

    always @(negedge rstn) begin
        hq.delete();
        vq.delete();
    end

    // An event sampled at edge e with delay d takes effect at edge e+1+d
    function automatic bit win_on(input bit use_v, input int d, input int w);
        bit on = 1'b0;
        if (use_v) begin
            foreach (vq[i]) if (edge_n >= vq[i] + 1 + d && edge_n < vq[i] + 1 + d + w) on = 1'b1;
        end else begin
            foreach (hq[i]) if (edge_n >= hq[i] + 1 + d && edge_n < hq[i] + 1 + d + w) on = 1'b1;
        end
        return on;
    endfunction

    function automatic int exp_lines(input int d, input int lw);
        int last_v = -1;
        int n = 0;
        int top = (1 << lw) - 1;
        foreach (vq[i]) if (vq[i] + 1 + d <= edge_n) last_v = vq[i];
        if (last_v < 0) return 0;
        foreach (hq[i]) if (hq[i] > last_v && hq[i] + 1 + d <= edge_n) n++;
        return (n > top) ? top : n;
    endfunction

    function automatic int exp_err(input int d);
        bit err = 1'b0;
        foreach (hq[i]) begin
            if (hq[i] + 1 + d == edge_n) begin
                bit framed = 1'b0;
                foreach (vq[j]) if (vq[j] < hq[i]) framed = 1'b1;
                if (!framed) err = 1'b1;
            end
        end
        return MEAS_ON ? int'(err) : 0;
    endfunction

    function automatic int exp_period(input int d);
        int h1 = -1;
        int h2 = -1;
        int gap;
        foreach (hq[i]) if (hq[i] + 1 + d <= edge_n) begin h1 = h2; h2 = hq[i]; end
        if (!MEAS_ON || h1 < 0) return 0;
        gap = h2 - h1;
        return (gap > 65535) ? 65535 : gap;
    endfunction

    int checks = 0;
    int errors = 0;
    bit run    = 1'b1;

    task automatic check_inst(input int k);
        logic a_hs, a_vs, a_fs, a_se, e_hs, e_vs, e_fs, e_se;
        int   a_lc, a_lp, e_lc, e_lp;
        a_hs = hs[k]; a_vs = vs[k]; a_fs = fs[k]; a_se = se[k];
        a_lp = int'(lp[k]);
        case (k)
            0:       a_lc = int'(lc0);
            1:       a_lc = int'(lc1);
            default: a_lc = int'(lc2);
        endcase
        e_hs = win_on(1'b0, P_DL[k], P_HW[k]) ? P_HP[k] : ~P_HP[k];
        e_vs = win_on(1'b1, P_DL[k], P_VW[k]) ? P_VP[k] : ~P_VP[k];
        e_fs = win_on(1'b1, P_DL[k], 1);
        e_se = exp_err(P_DL[k]) != 0;
        e_lc = exp_lines(P_DL[k], P_LW[k]);
        e_lp = exp_period(P_DL[k]);
        checks++;
        if (a_hs !== e_hs || a_vs !== e_vs || a_fs !== e_fs || a_se !== e_se ||
            a_lc != e_lc || a_lp != e_lp) begin
            errors++;
            $display("FAIL sync_u%0d edge %0d: got hs=%b vs=%b fs=%b err=%b lines=%0d period=%0d, want hs=%b vs=%b fs=%b err=%b lines=%0d period=%0d",
                     k, edge_n, a_hs, a_vs, a_fs, a_se, a_lc, a_lp, e_hs, e_vs, e_fs, e_se, e_lc, e_lp);
        end
    endtask

    always @(negedge clk) begin
        if (run) for (int k = 0; k < NI; k++) check_inst(k);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d want %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic cmd(input logic [5:0] dt, input logic v);
        bus.Rx_cmd_data_type = dt;
        bus.Rx_cmd_valid     = v;
        @(negedge clk);
        bus.Rx_cmd_valid     = 1'b0;
        bus.Rx_cmd_data_type = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.Rx_cmd_valid     = 1'b0;
        bus.Rx_cmd_data_type = '0;
        idle(1);
        chk("rst_hs_u0", hs[0], 1'b0);
        chk("rst_hs_u2_lowpol", hs[2], 1'b1);
        chk("rst_vs_u2_lowpol", vs[2], 1'b1);
        chk("rst_lines_u0", lc0, 0);
        idle(2);
        rstn = 1'b1;
        idle(5);

        // HSS outside a frame
        cmd(HSS, 1'b1);
        idle(1);
        chk("idle_hss_hs_u0", hs[0], 1'b1);
        chk("idle_hss_lines_u0", lc0, 0);
        chk("idle_hss_err_u0", se[0], MEAS_ON ? 1 : 0);
        idle(1);
        chk("idle_hss_one_cycle_u0", hs[0], 1'b0);
        idle(20);

        // Ignored commands
        cmd(6'h11, 1'b1); cmd(6'h31, 1'b1); cmd(HSS, 1'b0); cmd(VSS, 1'b0); cmd(6'h20, 1'b1);
        idle(20);

        // Frame start with VS_WIDTH=3, DLY=2 on u1
        cmd(VSS, 1'b1);
        idle(2);
        chk("vs_u1_before", vs[1], 1'b0);
        idle(1);
        chk("vs_u1_first", vs[1], 1'b1);
        chk("fs_u1_first", fs[1], 1'b1);
        idle(2);
        chk("vs_u1_last", vs[1], 1'b1);
        chk("fs_u1_once", fs[1], 1'b0);
        idle(1);
        chk("vs_u1_after", vs[1], 1'b0);
        idle(10);

        // Retrigger on u1 (HS_WIDTH=4): two HSS two cycles apart
        cmd(HSS, 1'b1); idle(1); cmd(HSS, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk("retrig_hs_u1", hs[1], 1'b1);
        end
        idle(1);
        chk("retrig_end_u1", hs[1], 1'b0);

        // Back-to-back HSS; u1 line counter saturates at 3
        cmd(HSS, 1'b1); cmd(HSS, 1'b1); cmd(HSS, 1'b1);
        idle(20);
        chk("lines_u0", lc0, 5);
        chk("lines_sat_u1", lc1, 3);
        chk("lines_u2", lc2, 5);

        // VSS immediately followed by HSS: frame restart
        cmd(VSS, 1'b1); cmd(HSS, 1'b1);
        idle(20);
        chk("restart_lines_u0", lc0, 1);
        chk("restart_lines_u2", lc2, 1);

        // Line period measurement
        cmd(HSS, 1'b1); idle(2199); cmd(HSS, 1'b1);
        idle(20);
        chk("period_2200_u0", lp[0], MEAS_ON ? 2200 : 0);
        idle(69979); cmd(HSS, 1'b1);
        idle(20);
        chk("period_sat_u0", lp[0], MEAS_ON ? 32'hFFFF : 0);

        // Reset in the middle of pulses with events still in flight
        cmd(VSS, 1'b1); cmd(HSS, 1'b1); cmd(HSS, 1'b1);
        idle(1);
        chk("pre_rst_vs_u1", vs[1], 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_vs_u1", vs[1], 1'b0);
        chk("async_rst_hs_u1", hs[1], 1'b0);
        chk("async_rst_hs_u2", hs[2], 1'b1);
        chk("async_rst_vs_u2", vs[2], 1'b1);
        chk("async_rst_lines_u0", lc0, 0);
        idle(2);
        rstn = 1'b1;
        idle(40);
        chk("flushed_vs_u2", vs[2], 1'b1);
        chk("flushed_hs_u2", hs[2], 1'b1);
        cmd(HSS, 1'b1);
        idle(1);
        chk("post_rst_idle_lines_u0", lc0, 0);
        chk("post_rst_idle_err_u0", se[0], MEAS_ON ? 1 : 0);
        idle(20);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
